// File: rtl/accum_looper_pkg.sv
// Shared sizing and state encoding for the accumulation warp looper.
package accum_looper_pkg;
  localparam int DIM    = 4;
  localparam int BW     = 16;
  localparam int N_CFG  = 4;
  localparam int ID_BW  = $clog2(N_CFG + 1);
  localparam int LVL_BW = $clog2(DIM + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic wraps0;
    logic fin;
  } tflag_t;
endpackage

// File: rtl/accum_looper_carry.sv
// Combinational stride/wrap/carry chain over the DIM-deep offset tuple.
module accum_looper_carry
  import accum_looper_pkg::*;
(
  input  logic [DIM-1:0][BW-1:0] ofs,
  input  logic [DIM-1:0][BW-1:0] beg,
  input  logic [DIM-1:0][BW-1:0] lim,
  input  logic [DIM-1:0][BW-1:0] stride,
  output logic [DIM-1:0][BW-1:0] nxt_ofs,
  output logic [LVL_BW-1:0]      lvl,
  output logic                   wraps0,
  output logic                   fin
);
  logic [DIM-1:0][BW:0] sum;
  logic [DIM-1:0]       wrap;
  logic                 c;

  // One extra bit so a stride overshooting 2^BW still counts as a wrap.
  for (genvar d = 0; d < DIM; d++) begin : g_dim
    assign sum[d]  = {1'b0, ofs[d]} + {1'b0, stride[d]};
    assign wrap[d] = sum[d] >= {1'b0, lim[d]};
  end

  always_comb begin
    nxt_ofs = ofs;
    lvl     = LVL_BW'(DIM);
    c       = 1'b1;
    for (int d = 0; d < DIM; d++) begin
      if (c) begin
        if (wrap[d]) nxt_ofs[d] = beg[d];
        else begin
          nxt_ofs[d] = sum[d][BW-1:0];
          lvl        = LVL_BW'(d);
          c          = 1'b0;
        end
      end
    end
    wraps0 = wrap[0];
    fin    = c;
  end
endmodule

// File: rtl/accum_warp_looper_gen.sv
// Nested offset loop with per-level config id ranges; emits one beat per id per tuple.
module accum_warp_looper_gen
  import accum_looper_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       cmd_rdy,
  output logic                       cmd_ack,
  input  logic [DIM-1:0][BW-1:0]     i_beg,
  input  logic [DIM-1:0][BW-1:0]     i_end,
  input  logic [DIM-1:0][BW-1:0]     i_stride,
  input  logic [DIM:0][ID_BW-1:0]    i_id_begs,
  input  logic [DIM:0][ID_BW-1:0]    i_id_ends,
  output logic                       out_rdy,
  input  logic                       out_ack,
  output logic [ID_BW-1:0]           o_id,
  output logic [DIM-1:0][BW-1:0]     o_ofs,
  output logic                       o_retire,
  output logic                       o_islast,
  output logic                       o_done
);
  state_e                  st, st_nxt;
  logic [DIM-1:0][BW-1:0]  beg_q, end_q, stride_q, ofs_q, stride_in;
  logic [DIM:0][ID_BW-1:0] idb_q, ide_q;
  logic [ID_BW-1:0]        id_q, id_end_q;
  tflag_t                  tf_q, la_tf;
  logic [DIM-1:0][BW-1:0]  adv_ofs, la_ofs, la_beg, la_end, la_stride, la_nxt;
  logic [LVL_BW-1:0]       adv_lvl, la_lvl;
  logic                    adv_w0, adv_fin, la_w0, la_fin;
  logic                    degen, empty, last_id, advance;
  logic                    unused_ok;

  for (genvar d = 0; d < DIM; d++) begin : g_stride
    assign stride_in[d] = (i_stride[d] == '0) ? BW'(1) : i_stride[d];
  end

  always_comb begin
    degen = 1'b0;
    for (int d = 0; d < DIM; d++)
      if (i_end[d] <= i_beg[d]) degen = 1'b1;
  end

  accum_looper_carry u_adv (
    .ofs(ofs_q), .beg(beg_q), .lim(end_q), .stride(stride_q),
    .nxt_ofs(adv_ofs), .lvl(adv_lvl), .wraps0(adv_w0), .fin(adv_fin)
  );

  // Lookahead: flags of the tuple about to be loaded (command tuple in IDLE).
  assign la_ofs    = (st == IDLE) ? i_beg     : adv_ofs;
  assign la_beg    = (st == IDLE) ? i_beg     : beg_q;
  assign la_end    = (st == IDLE) ? i_end     : end_q;
  assign la_stride = (st == IDLE) ? stride_in : stride_q;

  accum_looper_carry u_la (
    .ofs(la_ofs), .beg(la_beg), .lim(la_end), .stride(la_stride),
    .nxt_ofs(la_nxt), .lvl(la_lvl), .wraps0(la_w0), .fin(la_fin)
  );
  assign la_tf     = '{wraps0: la_w0, fin: la_fin};
  assign unused_ok = ^{la_nxt, la_lvl, adv_w0, adv_fin};

  assign empty   = !(id_q < id_end_q);
  assign last_id = ({1'b0, id_q} + (ID_BW+1)'(1)) == {1'b0, id_end_q};
  assign advance = (st == RUN) && (empty || (out_ack && last_id));

  assign out_rdy  = (st == RUN) && !empty;
  assign o_id     = id_q;
  assign o_ofs    = ofs_q;
  assign o_retire = out_rdy && last_id && (tf_q.wraps0 || tf_q.fin);
  assign o_islast = out_rdy && last_id && tf_q.fin;
  assign o_done   = (st == DONE);

  always_comb begin
    st_nxt  = st;
    cmd_ack = 1'b0;
    case (st)
      IDLE: if (cmd_rdy) begin
        cmd_ack = 1'b1;
        st_nxt  = degen ? DONE : RUN;
      end
      RUN:     if (advance && tf_q.fin) st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st       <= IDLE;
      beg_q    <= '0;
      end_q    <= '0;
      stride_q <= '0;
      ofs_q    <= '0;
      idb_q    <= '0;
      ide_q    <= '0;
      id_q     <= '0;
      id_end_q <= '0;
      tf_q     <= '0;
    end else begin
      st <= st_nxt;
      if (cmd_ack) begin
        beg_q    <= i_beg;
        end_q    <= i_end;
        stride_q <= stride_in;
        idb_q    <= i_id_begs;
        ide_q    <= i_id_ends;
        ofs_q    <= i_beg;
        id_q     <= i_id_begs[DIM];
        id_end_q <= i_id_ends[DIM];
        tf_q     <= la_tf;
      end else if (st == RUN) begin
        if (advance) begin
          if (!tf_q.fin) begin
            ofs_q    <= adv_ofs;
            id_q     <= idb_q[adv_lvl];
            id_end_q <= ide_q[adv_lvl];
            tf_q     <= la_tf;
          end
        end else if (out_ack) begin
          id_q <= id_q + ID_BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_accum_warp_looper_gen.sv
// Directed and randomised commands checked against a nested-loop reference model.
module tb_accum_warp_looper_gen;
  import accum_looper_pkg::*;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b1;
  logic                    cmd_rdy = 1'b0;
  logic                    cmd_ack;
  logic [DIM-1:0][BW-1:0]  i_beg = '0, i_end = '0, i_stride = '0;
  logic [DIM:0][ID_BW-1:0] i_id_begs = '0, i_id_ends = '0;
  logic                    out_rdy;
  logic                    out_ack = 1'b0;
  logic [ID_BW-1:0]        o_id;
  logic [DIM-1:0][BW-1:0]  o_ofs;
  logic                    o_retire, o_islast, o_done;

  accum_warp_looper_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack),
    .i_beg(i_beg), .i_end(i_end), .i_stride(i_stride),
    .i_id_begs(i_id_begs), .i_id_ends(i_id_ends),
    .out_rdy(out_rdy), .out_ack(out_ack), .o_id(o_id), .o_ofs(o_ofs),
    .o_retire(o_retire), .o_islast(o_islast), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cb[DIM], ce[DIM], cs[DIM], cib[DIM+1], cie[DIM+1];

  typedef struct {int id; int o[DIM]; bit ret; bit last;} beat_t;
  typedef struct {int o[DIM];} tup_t;
  beat_t exp_q[$];
  int    exp_cycles;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int eff(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  task automatic set_dim(input int d, input int b, input int e, input int s);
    cb[d] = b; ce[d] = e; cs[d] = s;
  endtask

  task automatic set_lvl(input int l, input int b, input int e);
    cib[l] = b; cie[l] = e;
  endtask

  // Reference: plain nested loops; level = highest dim differing from the previous tuple.
  task automatic build_model();
    tup_t tq[$];
    tup_t t;
    int   lv[$];
    exp_q.delete();
    exp_cycles = 0;
    for (int a3 = cb[3]; a3 < ce[3]; a3 += eff(cs[3]))
      for (int a2 = cb[2]; a2 < ce[2]; a2 += eff(cs[2]))
        for (int a1 = cb[1]; a1 < ce[1]; a1 += eff(cs[1]))
          for (int a0 = cb[0]; a0 < ce[0]; a0 += eff(cs[0])) begin
            t.o[0] = a0; t.o[1] = a1; t.o[2] = a2; t.o[3] = a3;
            tq.push_back(t);
          end
    for (int i = 0; i < tq.size(); i++) begin
      int k;
      k = DIM;
      if (i > 0)
        for (int d = 0; d < DIM; d++)
          if (tq[i].o[d] != tq[i-1].o[d]) k = d;
      lv.push_back(k);
    end
    for (int i = 0; i < tq.size(); i++) begin
      bit    fin, ret;
      int    lo, hi;
      beat_t b;
      fin = (i == tq.size() - 1);
      ret = fin || (lv[i+1] > 0);
      lo  = cib[lv[i]];
      hi  = cie[lv[i]];
      if (hi > lo) begin
        for (int id = lo; id < hi; id++) begin
          b.id = id;
          b.o  = tq[i].o;
          b.ret  = (id == hi - 1) && ret;
          b.last = (id == hi - 1) && fin;
          exp_q.push_back(b);
        end
        exp_cycles += hi - lo;
      end else begin
        exp_cycles += 1;
      end
    end
  endtask

  task automatic drive_cfg();
    for (int d = 0; d < DIM; d++) begin
      i_beg[d]    = BW'(cb[d]);
      i_end[d]    = BW'(ce[d]);
      i_stride[d] = BW'(cs[d]);
    end
    for (int l = 0; l <= DIM; l++) begin
      i_id_begs[l] = ID_BW'(cib[l]);
      i_id_ends[l] = ID_BW'(cie[l]);
    end
  endtask

  task automatic run_cmd(input int stall_pct, input bit timing, input int abort_at);
    int                     cyc;
    bit                     done, hold, ack;
    logic [ID_BW-1:0]       pid;
    logic [DIM-1:0][BW-1:0] pofs, eofs;
    build_model();
    @(negedge i_clk);
    drive_cfg();
    cmd_rdy = 1'b1;
    out_ack = 1'b0;
    #1 chk("cmd_ack", cmd_ack, 1);
    @(posedge i_clk);
    cyc = 0; done = 0; hold = 0; pid = '0; pofs = '0;
    while (!done && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
      if (abort_at != 0 && cyc == abort_at) begin
        i_rst_n = 1'b0; cmd_rdy = 1'b0; out_ack = 1'b0;
        #1;
        chk("rst_rdy", out_rdy, 0);
        chk("rst_ofs", o_ofs, 0);
        chk("rst_id", o_id, 0);
        chk("rst_flags", {o_retire, o_islast, o_done}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) begin
          @(negedge i_clk);
          chk("post_rst_idle", {out_rdy, o_done}, 0);
        end
        return;
      end
      if (hold) chk("stall_hold", {o_id, o_ofs}, {pid, pofs});
      hold = 0;
      if (o_done) begin
        done = 1; cmd_rdy = 1'b0; out_ack = 1'b0;
        chk("beats_left", exp_q.size(), 0);
        if (timing) chk("done_cycle", cyc, exp_cycles + 1);
      end else begin
        chk("cmd_ack_busy", cmd_ack, 0);
        if (out_rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", out_rdy, 0);
            out_ack = 1'b0;
          end else begin
            for (int d = 0; d < DIM; d++) eofs[d] = BW'(exp_q[0].o[d]);
            chk("o_id", o_id, exp_q[0].id);
            chk("o_ofs", o_ofs, eofs);
            chk("o_retire", o_retire, exp_q[0].ret);
            chk("o_islast", o_islast, exp_q[0].last);
            ack = ($urandom_range(0, 99) >= stall_pct);
            out_ack = ack;
            if (ack) void'(exp_q.pop_front());
            else begin hold = 1; pid = o_id; pofs = o_ofs; end
          end
        end else begin
          out_ack = 1'b0;
          chk("bubble_flags", {o_retire, o_islast}, 0);
        end
      end
    end
    chk("timeout", done, 1);
    @(negedge i_clk);
    chk("done_pulse", o_done, 0);
    chk("post_rdy", out_rdy, 0);
  endtask

  task automatic base_cfg();
    for (int d = 0; d < DIM; d++) set_dim(d, 0, 1, 1);
    for (int l = 0; l <= DIM; l++) set_lvl(l, 0, 1);
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    #10;
    chk("reset_rdy", out_rdy, 0);
    chk("reset_outs", {o_id, o_ofs, o_retire, o_islast, o_done, cmd_ack}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 2x2 walk, ids 0,1 everywhere
    base_cfg();
    set_dim(0, 0, 2, 1); set_dim(1, 0, 2, 1);
    for (int l = 0; l <= DIM; l++) set_lvl(l, 0, 2);
    run_cmd(0, 1, 0);

    // stride 3 from 1 to 8: 1,4,7
    base_cfg();
    set_dim(0, 1, 8, 3);
    run_cmd(0, 1, 0);

    // empty level-0 range: only first tuple beats, others bubble
    base_cfg();
    set_dim(0, 0, 3, 1);
    set_lvl(0, 2, 2);
    run_cmd(0, 1, 0);

    // degenerate dim 1
    base_cfg();
    set_dim(0, 0, 2, 1); set_dim(1, 5, 5, 1);
    run_cmd(0, 1, 0);

    // strides overshooting the BW range
    base_cfg();
    set_dim(0, 65530, 65535, 4); set_dim(1, 0, 65535, 40000);
    set_lvl(0, 1, 3); set_lvl(1, 0, 4); set_lvl(DIM, 2, 4);
    run_cmd(0, 1, 0);

    // zero stride behaves as one
    base_cfg();
    set_dim(0, 0, 3, 0); set_dim(2, 2, 4, 0);
    set_lvl(2, 3, 4);
    run_cmd(0, 1, 0);

    // randomised configs, each run unstalled then heavily stalled
    for (int n = 0; n < 10; n++) begin
      for (int d = 0; d < DIM; d++) begin
        int b;
        b = $urandom_range(0, 20);
        set_dim(d, b, b + $urandom_range(1, (d < 2) ? 6 : 3), $urandom_range(0, 3));
      end
      for (int l = 0; l <= DIM; l++) set_lvl(l, $urandom_range(0, 4), $urandom_range(0, 4));
      run_cmd(0, 1, 0);
      run_cmd(50, 0, 0);
    end

    // abort mid-run via reset, then a clean command
    base_cfg();
    set_dim(0, 0, 3, 1); set_dim(1, 0, 3, 1);
    for (int l = 0; l <= DIM; l++) set_lvl(l, 0, 2);
    run_cmd(0, 0, 4);
    run_cmd(30, 0, 0);
    run_cmd(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_warp_looper_gen.md
# accum_warp_looper_gen

Parametrised successor of the accumulation warp looper in the TileAccumUnit address pipeline. It accepts one block command over a rdy/ack handshake and walks a DIM-deep nested offset loop with per-dimension programmable stride. For every offset tuple it emits one beat per config id in a level-selected id range. It flags retire and last beats, skips empty ranges, and pulses a completion strobe. Downstream memory-offset and vector stages consume its beat stream unchanged.

## Interface
- DIM, 4, number of loop dimensions (dim 0 innermost)
- BW, 16, offset/stride width (WORK_BW)
- N_CFG, 4, number of configs; ID_BW = $clog2(N_CFG+1)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- cmd_rdy  in  1  command valid
- cmd_ack  out  1  command accepted; combinational, = cmd_rdy && state==IDLE
- i_beg / i_end / i_stride  in  BW×DIM  loop bounds and stride per dim; stride 0 treated as 1
- i_id_begs / i_id_ends  in  ID_BW×(DIM+1)  id range per level
- out_rdy  out  1  beat valid
- out_ack  in  1  beat consumed (must only rise while out_rdy)
- o_id  out  ID_BW  config id of beat
- o_ofs  out  BW×DIM  current offset tuple
- o_retire  out  1  last id of a tuple that closes dim 0 (or of final tuple)
- o_islast  out  1  final beat of the command
- o_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs and registers 0.
- IDLE: on cmd_ack, latch bounds, strides, id tables. Set ofs=beg and level k=DIM. If any dim has end<=beg (unsigned), go to DONE (zero beats); else go to RUN.
- Level k of a tuple: DIM for the first tuple. Otherwise k is the index of the highest dim that incremented; all lower dims wrapped to beg.
- Id range for tuple = [i_id_begs[k], i_id_ends[k]) from the latched tables. Ranges with beg>=end are empty: tuple consumes one cycle with out_rdy=0, no beat.
- Non-empty tuple: id counter starts at range beg. Beat presented with out_rdy=1; on out_ack, id++. On the last id, advance the tuple.
- Tuple advance: carry chain from dim 0. nxt = ofs[d]+stride[d] computed at BW+1 bits. If nxt >= end[d], dim wraps to beg[d] and carries; otherwise ofs[d]=nxt and the chain stops. Carry out of dim DIM-1 means the loop is finished.
- o_retire = last id of tuple && (dim 0 wraps on next advance || final tuple).
- o_islast = last id of final tuple (final tuple = every dim wraps on next advance).
- Finish: the out_ack of the islast beat moves to DONE. If the final tuple is empty, its skip cycle moves to DONE instead.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Output regs hold stable while out_rdy && !out_ack.
- Asynchronous reset mid-command aborts immediately. Outputs clear, state goes to IDLE, and no o_done is emitted.

## Timing
- cmd_ack in cycle T → first beat out_rdy at T+1 (or first skip cycle at T+1).
- Throughput: one beat per cycle with out_ack held high; no bubble between tuples or ids.
- Empty tuple: exactly 1 bubble cycle.
- o_done asserted the cycle after the islast ack (or after the final skip / degenerate accept).
- cmd_ack never asserted outside IDLE, so the next command is accepted at the earliest in the cycle after o_done.

## Structure
- Shared package accum_looper_pkg: DIM, BW, N_CFG, ID_BW; state enum typedef {IDLE, RUN, DONE}.
- Sub-module accum_looper_carry: combinational stride/wrap/carry chain. Outputs the next ofs tuple, level k, wraps0 and final flags. Instantiated once for advance and once for lookahead of retire/islast.

## Test plan
- DIM=2, beg=(0,0), end=(2,2), stride 1, all ranges [0,2) → 8 beats; ofs order (0,0),(1,0),(0,1),(1,1) with ids 0,1 each; retire on ids at ofs(1,x); islast on 8th; o_done next cycle.
- Stride 3, beg 1, end 8 in dim 0 (other dims single iteration) → dim-0 ofs 1,4,7 then wrap; value 10 never emitted.
- id_begs[0]=id_ends[0]=2, level DIM range [0,1) → only first tuple emits beats; others bubble 1 cycle each; o_done after final skip.
- end[1]=beg[1]=5 → cmd_ack, zero beats, o_done at T+1.
- Randomised out_ack stalls → o_id/o_ofs stable under stall; beat sequence identical to no-stall run.
- i_rst_n low mid-RUN → outputs 0 same cycle, IDLE; new command accepted and completes correctly.
